// File: rtl/button_stepper.sv
// Debounced up/down pushbutton stepper with hold-to-auto-repeat and a both-pressed lockout.
// Latency: 2 + DEBOUNCE_CYCLES + 1 cycles from clean press to step; no backpressure, step is a one-shot pulse.
module button_stepper #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnUp,
    input  logic btnDn,
    output logic step,
    output logic UP,
    output logic held
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]      w_raw;
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_deb;
    logic [DB_W-1:0] r_db_cnt [2];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             r_step;
    logic             r_up;
    logic             r_held;
    logic             w_step_nxt;
    logic             w_up_nxt;
    logic             w_up_deb;
    logic             w_dn_deb;
    logic             w_latched_deb;
    logic             w_opposite_deb;

    assign w_raw = {btnDn, btnUp};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= ~r_deb[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_up_deb = r_deb[0];
    assign w_dn_deb = r_deb[1];

    // The direction register doubles as the record of which button owns the current hold.
    assign w_latched_deb  = r_up ? w_up_deb : w_dn_deb;
    assign w_opposite_deb = r_up ? w_dn_deb : w_up_deb;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_step_nxt  = 1'b0;
        w_up_nxt    = r_up;
        case (r_state)
            IDLE: begin
                if (w_up_deb ^ w_dn_deb) begin
                    w_step_nxt  = 1'b1;
                    w_up_nxt    = w_up_deb;
                    w_timer_nxt = '0;
                    w_state_nxt = DELAY;
                end else if (w_up_deb && w_dn_deb) begin
                    w_state_nxt = LOCKOUT;
                end
            end
            DELAY, REPEAT: begin
                // Release wins over a conflicting press, and both win over timer expiry.
                if (!w_latched_deb) begin
                    w_state_nxt = IDLE;
                end else if (w_opposite_deb) begin
                    w_state_nxt = LOCKOUT;
                end else if (r_timer == ((r_state == DELAY) ? DLY_LAST : PER_LAST)) begin
                    w_step_nxt  = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = REPEAT;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            LOCKOUT: begin
                if (!w_up_deb && !w_dn_deb) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_step  <= 1'b0;
            r_up    <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_step  <= w_step_nxt;
            r_up    <= w_up_nxt;
            r_held  <= (w_state_nxt == DELAY) || (w_state_nxt == REPEAT);
        end
    end

    assign step = r_step;
    assign UP   = r_up;
    assign held = r_held;

endmodule

// File: doc/button_stepper.md
BUTTON_STEPPER -- requirements
Module: button_stepper

Parameters
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the consecutive stable cycles needed to accept a button level change.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000, giving the cycles from the first step to the first auto-repeat step.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, giving the cycles between consecutive auto-repeat steps.

Interface
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port btnUp, input, 1 bit: raw asynchronous pushbutton, active-high, requests increment.
REQ-007 Port btnDn, input, 1 bit: raw asynchronous pushbutton, active-high, requests decrement.
REQ-008 Port step, output, 1 bit: one-cycle pulse; the downstream 0-7 counter advances once per pulse.
REQ-009 Port UP, output, 1 bit: direction of the most recent step; 1 = increment, 0 = decrement.
REQ-010 Port held, output, 1 bit: high while a press is being held in DELAY or REPEAT.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Debounce, per button: a counter SHALL clear whenever the synchronized level equals the debounced level.
REQ-013 Otherwise the counter SHALL increment, and the debounced level SHALL flip in the cycle it reaches DEBOUNCE_CYCLES-1, with the counter clearing.
REQ-014 Debounce counters SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL NOT wrap.
REQ-015 FSM states SHALL be IDLE, DELAY, REPEAT and LOCKOUT; the reset state SHALL be IDLE.
REQ-016 IDLE, exactly one debounced button high: step=1 for one cycle, UP=1 for btnUp or 0 for btnDn, timer cleared, go to DELAY.
REQ-017 IDLE, both debounced buttons high: go to LOCKOUT with no step; with neither high, stay.
REQ-018 DELAY: timer increments each cycle; on reaching REPEAT_DELAY-1: step=1, timer cleared, go to REPEAT.
REQ-019 REPEAT: timer increments each cycle; on reaching REPEAT_PERIOD-1: step=1, timer cleared, stay in REPEAT.
REQ-020 DELAY or REPEAT, latched button debounced low: go to IDLE with no step, even if the timer expires that cycle.
REQ-021 DELAY or REPEAT, opposite button debounced high: go to LOCKOUT with no step; release takes priority if both occur in one cycle.
REQ-022 LOCKOUT: step SHALL stay 0; go to IDLE only when both debounced buttons are low.
REQ-023 UP SHALL change only in a cycle where step=1, and SHALL hold its value otherwise.
REQ-024 held SHALL be a registered decode of the DELAY and REPEAT states.
REQ-025 step SHALL never be high in two consecutive cycles.
REQ-026 Latency from a clean btnUp rise to step SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-027 The repeat timer SHALL be wide enough for max(REPEAT_DELAY, REPEAT_PERIOD) and SHALL NOT wrap.

Reset
REQ-028 While reset=0, all of the following SHALL hold asynchronously:
- step=0, UP=0, held=0;
- FSM in IDLE;
- synchronizers, debounced levels and all counters at 0.
REQ-029 Reset deasserted mid-press SHALL re-debounce the button and produce a fresh first step, with no spurious pulse at deassertion.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-030 Single press: btnUp high 10 cycles, then low -> one step pulse 7 cycles after the rise, UP=1, held high then low, no further steps.
REQ-031 Bounce: btnDn toggles every 2 cycles for 12 cycles, then stays high -> no step during the toggling, exactly one step 7 cycles after it settles, UP=0.
REQ-032 Auto-repeat: btnUp held 60 cycles -> steps at relative cycles 0, 20, 28, 36, 44, 52; UP=1 throughout.
REQ-033 Conflict: btnUp held; btnDn pressed at step+10 -> LOCKOUT, held=0, no steps until both are released; a later btnDn press -> step with UP=0.
REQ-034 Async reset: reset pulled low mid-REPEAT between clock edges -> step, held and UP are 0 immediately; after release with btnUp still high -> first step 7 cycles later.
REQ-035 Release on expiry: btnUp debounced-low in the cycle the DELAY timer hits 19 -> no step, FSM in IDLE.
